// File: rtl/test_sequencer_pkg.sv
// Shared types and constants for the cell-tester sequencer.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds the FSM state enum, the saturating error ceiling and the SETTLE
// stretch added when TEST_SEQUENCER_SYNC_EN puts a 2-flop synchronizer
// in front of the response compare.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int         ERR_W   = 8;
    localparam logic [7:0] ERR_MAX = 8'd255;

    // Wait counter must hold 15 + 2 when the synchronizer is built in.
    localparam int CNT_W = 5;

`ifdef TEST_SEQUENCER_SYNC_EN
    // Two extra settle cycles cover the synchronizer's flop delay.
    localparam int SETTLE_EXTRA = 2;
`else
    localparam int SETTLE_EXTRA = 0;
`endif

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Stimulus/expected-response vector channel into the sequencer.
// Latency: none (wires only).
// Backpressure: valid/ready; a pair transfers on a cycle with vec_valid & vec_ready.
//
// master: vector source (drives vec_valid, vec_in, exp_in, vec_last)
// slave : sequencer      (drives vec_ready)
// IN_W/OUT_W must match the parameters of the attached test_sequencer.
interface test_sequencer_if
    import test_sequencer_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
);
    logic             vec_valid;
    logic             vec_ready;
    logic [IN_W-1:0]  vec_in;
    logic [OUT_W-1:0] exp_in;
    logic             vec_last;

    modport master (
        output vec_valid, vec_in, exp_in, vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_in, exp_in, vec_last,
        output vec_ready
    );
endinterface

// File: rtl/test_sequencer_sync_2ff.sv
// Two-flop synchronizer for the tester response bus.
// Latency: 2 clk cycles.
// Backpressure: none (free-running).
//
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
// Only instantiated when TEST_SEQUENCER_SYNC_EN is defined. The response is
// held stable across the whole settle window, so per-bit synchronization of a
// multi-bit bus is safe here.
module sync_2ff
    import test_sequencer_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/test_sequencer.sv
// Sequences stimulus/expected pairs into a cell tester, triggers it, waits, compares the response.
// Latency: acceptance to done = settle + 2 cycles (settle + 4 with TEST_SEQUENCER_SYNC_EN) for the last pair.
// Backpressure: vec_ready high only in LOAD; one pair accepted per trigger/settle/sample round.
//
// Ports: clk, rst (async active-high); start/abort run control; settle (wait cycles,
// sampled when leaving PULSE); vec (test_sequencer_if.slave vector channel);
// mode_o/trigger_o/source_o to the tester, target_i from it; busy/done/pass/err_cnt status.
// Option macro: TEST_SEQUENCER_SYNC_EN -- synchronize target_i through sync_2ff
// and stretch SETTLE by two cycles.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         settle,
    test_sequencer_if.slave    vec,
    output logic               mode_o,
    output logic               trigger_o,
    output logic [IN_W-1:0]    source_o,
    input  logic [OUT_W-1:0]   target_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt
);
    state_t              state;
    logic [OUT_W-1:0]    exp_q;
    logic                last_q;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    settle_ld;
    logic [OUT_W-1:0]    resp;
    logic [ERR_W-1:0]    err_nxt;

    // Manual-trigger mode only; the ring oscillator is never enabled.
    assign mode_o = 1'b0;

`ifdef TEST_SEQUENCER_SYNC_EN
    sync_2ff #(.W(OUT_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (target_i),
        .q   (resp)
    );
`else
    assign resp = target_i;
`endif

    assign settle_ld = CNT_W'(settle) + CNT_W'(SETTLE_EXTRA);

    // Error count as it will stand after the SAMPLE in progress; pass is
    // derived from this so the final compare is included.
    always_comb begin
        err_nxt = err_cnt;
        if (resp != exp_q)
            err_nxt = sat_inc(err_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            source_o      <= '0;
            exp_q         <= '0;
            last_q        <= 1'b0;
            cnt           <= '0;
            err_cnt       <= '0;
            pass          <= 1'b0;
            done          <= 1'b0;
            trigger_o     <= 1'b0;
            busy          <= 1'b0;
            vec.vec_ready <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // Abandon the run: results registers keep their last values.
            state         <= S_IDLE;
            trigger_o     <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            vec.vec_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort outranks start even while idle.
                    if (start && !abort) begin
                        state         <= S_LOAD;
                        err_cnt       <= '0;
                        busy          <= 1'b1;
                        vec.vec_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (vec.vec_valid) begin
                        source_o      <= vec.vec_in;
                        exp_q         <= vec.exp_in;
                        last_q        <= vec.vec_last;
                        vec.vec_ready <= 1'b0;
                        trigger_o     <= 1'b1;
                        state         <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    trigger_o <= 1'b0;
                    // A zero wait skips SETTLE entirely.
                    if (settle_ld == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt   <= settle_ld;
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1))
                        state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    err_cnt <= err_nxt;
                    if (last_q) begin
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                        state <= S_DONE;
                    end else begin
                        vec.vec_ready <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    trigger_o     <= 1'b0;
                    done          <= 1'b0;
                    busy          <= 1'b0;
                    vec.vec_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: directed runs plus randomized vector runs.
// Latency: n/a (testbench).
// Backpressure: bench waits on vec_ready before offering each pair.
module tb_test_sequencer;
    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
`ifdef TEST_SEQUENCER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [3:0]       settle;
    logic             mode_o;
    logic             trigger_o;
    logic [IN_W-1:0]  source_o;
    logic [OUT_W-1:0] target_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_cnt;

    test_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) vif ();

    test_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .settle    (settle),
        .vec       (vif),
        .mode_o    (mode_o),
        .trigger_o (trigger_o),
        .source_o  (source_o),
        .target_i  (target_i),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse monitor, sampled on the falling edge.
    int neg_idx       = 0;
    int trig_cnt      = 0;
    int done_cnt      = 0;
    int last_trig_idx = 0;
    int last_done_idx = 0;
    always @(negedge clk) begin
        neg_idx++;
        if (trigger_o === 1'b1) begin
            trig_cnt++;
            last_trig_idx = neg_idx;
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_idx = neg_idx;
        end
    end

    // Vector tables for one run.
    logic [IN_W-1:0]  v_vec [300];
    logic [OUT_W-1:0] v_exp [300];
    logic [OUT_W-1:0] v_rsp [300];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 all responses match, 1 all mismatch, 2 random mix.
    task automatic gen(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic mis;
            v_vec[i] = IN_W'($urandom_range(1, 255));
            v_exp[i] = OUT_W'($urandom_range(0, 15));
            mis = (mode == 1) || (mode == 2 && $urandom_range(0, 2) == 0);
            v_rsp[i] = mis ? (v_exp[i] ^ OUT_W'($urandom_range(1, 15))) : v_exp[i];
        end
    endtask

    // Reference: mismatches counted, capped at 255.
    function automatic int model_errs(input int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (v_rsp[i] != v_exp[i]) e++;
        return (e > 255) ? 255 : e;
    endfunction

    // Runs n pairs. abort_at >= 0 aborts two cycles after that pair is taken;
    // start_at >= 0 raises start while that pair is offered.
    task automatic run_vectors(input int n, input logic [3:0] st, input int abort_at,
                               input int start_at, input string tag);
        int guard;
        settle = st;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (vif.vec_ready !== 1'b1 && guard < 60);
            if (vif.vec_ready !== 1'b1) begin
                check({tag, "_ready_timeout"}, 32'(vif.vec_ready), 32'd1);
                return;
            end
            vif.vec_valid = 1'b1;
            vif.vec_in    = v_vec[i];
            vif.exp_in    = v_exp[i];
            vif.vec_last  = (i == n - 1);
            target_i      = v_rsp[i];
            if (i == start_at) start = 1'b1;
            @(posedge clk);
            #1;
            vif.vec_valid = 1'b0;
            start         = 1'b0;
            if (i == abort_at) begin
                @(negedge clk);
                @(negedge clk);
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_trig"}, 32'(trigger_o), 32'd0);
                check({tag, "_abort_rdy"}, 32'(vif.vec_ready), 32'd0);
                @(negedge clk);
                return;
            end
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (done !== 1'b1 && guard < 60);
        if (done !== 1'b1) begin
            check({tag, "_done_timeout"}, 32'(done), 32'd1);
            return;
        end
        @(negedge clk);
    endtask

    int tb0, db0, n, exp_err;
    logic [3:0] st;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; settle = '0; target_i = '0;
        vif.vec_valid = 1'b0; vif.vec_in = '0; vif.exp_in = '0; vif.vec_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_trig", 32'(trigger_o), 32'd0);
        check("rst_rdy", 32'(vif.vec_ready), 32'd0);
        check("rst_mode", 32'(mode_o), 32'd0);
        check("rst_src", 32'(source_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single vector, known latency.
        v_vec[0] = 8'hA5; v_exp[0] = 4'h6; v_rsp[0] = 4'h6;
        tb0 = trig_cnt; db0 = done_cnt;
        run_vectors(1, 4'd3, -1, -1, "single");
        check("single_lat", 32'(last_done_idx - last_trig_idx), 32'(5 + EXTRA));
        check("single_trig", 32'(trig_cnt - tb0), 32'd1);
        check("single_done", 32'(done_cnt - db0), 32'd1);
        check("single_pass", 32'(pass), 32'd1);
        check("single_err", 32'(err_cnt), 32'd0);
        check("single_src", 32'(source_o), 32'hA5);
        check("single_busy", 32'(busy), 32'd0);
        check("single_mode", 32'(mode_o), 32'd0);

        // Three vectors, middle one mismatches; start raised mid-run is ignored.
        gen(3, 0);
        v_rsp[1] = v_exp[1] ^ 4'h9;
        tb0 = trig_cnt; db0 = done_cnt;
        run_vectors(3, 4'd2, -1, 2, "three");
        check("three_err", 32'(err_cnt), 32'd1);
        check("three_pass", 32'(pass), 32'd0);
        check("three_trig", 32'(trig_cnt - tb0), 32'd3);
        check("three_done", 32'(done_cnt - db0), 32'd1);
        check("three_src", 32'(source_o), 32'(v_vec[2]));

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 8);
            st = 4'($urandom_range(0, 15));
            gen(n, 2);
            exp_err = model_errs(n);
            tb0 = trig_cnt; db0 = done_cnt;
            run_vectors(n, st, -1, -1, "rand");
            check("rand_err", 32'(err_cnt), 32'(exp_err));
            check("rand_pass", 32'(pass), 32'(exp_err == 0));
            check("rand_trig", 32'(trig_cnt - tb0), 32'(n));
            check("rand_done", 32'(done_cnt - db0), 32'd1);
            check("rand_p2s", 32'(last_done_idx - last_trig_idx - 1), 32'(int'(st) + 1 + EXTRA));
        end

        // 300 mismatches saturate the counter.
        gen(300, 1);
        tb0 = trig_cnt;
        run_vectors(300, 4'd0, -1, -1, "sat");
        check("sat_err", 32'(err_cnt), 32'd255);
        check("sat_pass", 32'(pass), 32'd0);
        check("sat_trig", 32'(trig_cnt - tb0), 32'd300);

        // settle=0: PULSE to SAMPLE distance, leaves pass=1.
        gen(1, 0);
        run_vectors(1, 4'd0, -1, -1, "zero");
        check("zero_p2s", 32'(last_done_idx - last_trig_idx - 1), 32'(1 + EXTRA));
        check("zero_pass", 32'(pass), 32'd1);

        // Abort during SETTLE of the second pair; first pair mismatched.
        gen(2, 0);
        v_rsp[0] = v_exp[0] ^ 4'h3;
        tb0 = trig_cnt; db0 = done_cnt;
        run_vectors(2, 4'd8, 1, -1, "abort");
        repeat (30) @(negedge clk);
        check("abort_done", 32'(done_cnt - db0), 32'd0);
        check("abort_trig", 32'(trig_cnt - tb0), 32'd2);
        check("abort_err", 32'(err_cnt), 32'd1);
        check("abort_pass", 32'(pass), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);

        // abort and start together while idle: stays idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_rdy", 32'(vif.vec_ready), 32'd0);

        // Asynchronous reset while in LOAD.
        db0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("preload_rdy", 32'(vif.vec_ready), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdy", 32'(vif.vec_ready), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_err", 32'(err_cnt), 32'd0);
        check("arst_src", 32'(source_o), 32'd0);
        check("arst_trig", 32'(trigger_o), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_nodone", 32'(done_cnt - db0), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // Recovery after reset.
        n = 3;
        gen(n, 2);
        exp_err = model_errs(n);
        run_vectors(n, 4'd1, -1, -1, "recover");
        check("recover_err", 32'(err_cnt), 32'(exp_err));
        check("recover_pass", 32'(pass), 32'(exp_err == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
